m_div_seq: RTL and testbench

- Parametrised, multi-cycle radix-2 restoring divider for the M-extension datapath. It computes DIV, DIVU, REM and REMU for any operand width XLEN.
- It replaces single-step combinational divide support with a self-sequenced unit. The unit has a valid/ready handshake, tag passthrough, pipeline-flush (kill) support, and RISC-V corner-case handling.
- It sits beside the multiplier/modular-arithmetic ALU in the execute stage and returns its result to writeback through its own handshake.

---
 rtl/m_div_seq.sv | 133 +++++++++++++
 tb/tb_m_div_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_div_seq.sv
// m_div_seq: self-sequenced radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Operands are reduced to magnitudes on accept. One quotient bit is produced
// per CALC cycle. Signs are restored in FIX. Divide-by-zero and signed
// overflow bypass the iteration and complete immediately.
module m_div_seq #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             kill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   counter;
   logic            op_rem;
   logic            neg_q, neg_r;
   logic [XLEN-1:0] z, d;
   // The partial remainder always stays below D, so XLEN bits hold it.
   // The extra bit exists only in the shifted/trial values.
   logic [XLEN-1:0] r;

   logic            accept, is_signed, a_neg, b_neg, div_zero, overflow, special;
   logic [XLEN-1:0] special_res;
   logic [XLEN:0]   r_sh, trial;

   // Two's-complement negate (modulo 2^XLEN) when neg is set
   function automatic logic [XLEN-1:0] apply_sign(input logic neg, input logic [XLEN-1:0] v);
      logic signed [XLEN-1:0] sv;
      sv = v;
      return neg ? -sv : sv;
   endfunction

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign accept    = in_valid && in_ready && !kill;
   assign is_signed = ~in_op[0];
   assign a_neg     = is_signed & in_a[XLEN-1];
   assign b_neg     = is_signed & in_b[XLEN-1];
   assign div_zero  = (in_b == '0);
   assign overflow  = is_signed && (in_a == MOST_NEG) && (in_b == '1);
   assign special   = div_zero | overflow;
   assign r_sh      = {r, z[XLEN-1]};
   assign trial     = r_sh - {1'b0, d};

   // Result of the single-cycle corner cases
   always_comb begin
      special_res = '0;
      if (div_zero) special_res = in_op[1] ? in_a : '1;
      else          special_res = in_op[1] ? '0   : in_a;
   end

   // State register
   always_ff @(posedge clk) begin
      if (resetn) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic; kill always returns to IDLE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = special ? DONE : CALC;
         CALC: if (counter == '0) state_nx = FIX;
         FIX:  state_nx = DONE;
         DONE: if (out_valid && out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (kill) state_nx = IDLE;
   end

   // Operand capture, iteration step, sign fix-up and output handshake
   always_ff @(posedge clk) begin
      if (resetn) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
         counter    <= '0;
      end else if (kill) begin
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op_rem  <= in_op[1];
               out_tag <= in_tag;
               neg_q   <= a_neg ^ b_neg;
               neg_r   <= a_neg;
               z       <= apply_sign(a_neg, in_a);
               d       <= apply_sign(b_neg, in_b);
               r       <= '0;
               counter <= CW'(XLEN - 1);
               if (special) begin
                  out_result <= special_res;
                  out_valid  <= 1'b1;
               end
            end
            CALC: begin
               if (!trial[XLEN]) begin
                  r <= trial[XLEN-1:0];
                  z <= {z[XLEN-2:0], 1'b1};
               end else begin
                  r <= r_sh[XLEN-1:0];
                  z <= {z[XLEN-2:0], 1'b0};
               end
               counter <= counter - CW'(1);
            end
            FIX: begin
               out_result <= op_rem ? apply_sign(neg_r, r) : apply_sign(neg_q, z);
               out_valid  <= 1'b1;
            end
            DONE: if (out_valid && out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_m_div_seq.sv
// tb_m_div_seq: directed vectors for m_div_seq at XLEN=32 and XLEN=8, plus
// hand-written backpressure, kill and reset sequences.
module tb_m_div_seq;

   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic        in_valid, in_ready, kill, out_valid, out_ready, busy;
   logic [1:0]  in_op;
   logic [31:0] in_a, in_b, out_result;
   logic [4:0]  in_tag, out_tag;

   logic        v8, rdy8, kill8, ov8, ordy8, busy8;
   logic [1:0]  op8;
   logic [7:0]  a8, b8, res8;
   logic [4:0]  tag8, otag8;

   m_div_seq #(.XLEN(32), .TAG_W(5)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .kill(kill),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_tag(out_tag), .busy(busy));

   m_div_seq #(.XLEN(8), .TAG_W(5)) dut8 (
      .clk(clk), .resetn(resetn), .in_valid(v8), .in_ready(rdy8),
      .in_op(op8), .in_a(a8), .in_b(b8), .in_tag(tag8), .kill(kill8),
      .out_valid(ov8), .out_ready(ordy8), .out_result(res8),
      .out_tag(otag8), .busy(busy8));

   int ncmp = 0;
   int nfail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  tag;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[14];
   vec_t vecs8[4];

   // Issue one request on the 32-bit unit and wait for out_valid
   task automatic txn32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] res, output logic [4:0] tg,
                        output int lat);
      in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = ~a; in_b = ~b; in_op = ~op; in_tag = ~tag;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      res = out_result;
      tg  = out_tag;
   endtask

   task automatic drain32();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic txn8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [4:0] tag, output logic [7:0] res, output logic [4:0] tg,
                       output int lat);
      op8 = op; a8 = a; b8 = b; tag8 = tag; v8 = 1'b1;
      @(posedge clk); #1;
      v8 = 1'b0; a8 = ~a; b8 = ~b; op8 = ~op;
      lat = 1;
      while (!ov8 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      res = res8;
      tg  = otag8;
      ordy8 = 1'b1;
      @(posedge clk); #1;
      ordy8 = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] res;
      logic [4:0]  tg;
      logic [7:0]  r8;
      int          lat;
      logic        seen;

      vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          5'h1A, 32'd14,         34};
      vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          5'h01, 32'd2,          34};
      vecs[2]  = '{OP_DIV,  32'hFFFFFFF9,   32'd2,          5'h02, 32'hFFFFFFFD,   34};
      vecs[3]  = '{OP_REM,  32'hFFFFFFF9,   32'd2,          5'h03, 32'hFFFFFFFF,   34};
      vecs[4]  = '{OP_REM,  32'd7,          32'hFFFFFFFE,   5'h04, 32'd1,          34};
      vecs[5]  = '{OP_DIV,  32'd7,          32'hFFFFFFFE,   5'h05, 32'hFFFFFFFD,   34};
      vecs[6]  = '{OP_DIV,  32'h1234,       32'd0,          5'h06, 32'hFFFFFFFF,   1};
      vecs[7]  = '{OP_REMU, 32'h1234,       32'd0,          5'h07, 32'h1234,       1};
      vecs[8]  = '{OP_REM,  32'hFFFFFFFB,   32'd0,          5'h08, 32'hFFFFFFFB,   1};
      vecs[9]  = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   5'h09, 32'h80000000,   1};
      vecs[10] = '{OP_REM,  32'h80000000,   32'hFFFFFFFF,   5'h0A, 32'd0,          1};
      vecs[11] = '{OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   5'h0B, 32'd0,          34};
      vecs[12] = '{OP_REMU, 32'h80000000,   32'hFFFFFFFF,   5'h0C, 32'h80000000,   34};
      vecs[13] = '{OP_DIVU, 32'hFFFFFFFF,   32'd1,          5'h1F, 32'hFFFFFFFF,   34};

      vecs8[0] = '{OP_DIV,  32'h81, 32'h03, 5'h11, 32'hD6, 10};
      vecs8[1] = '{OP_REM,  32'h81, 32'h03, 5'h12, 32'hFF, 10};
      vecs8[2] = '{OP_DIVU, 32'h81, 32'h03, 5'h13, 32'h2B, 10};
      vecs8[3] = '{OP_DIV,  32'h80, 32'hFF, 5'h14, 32'h80, 1};

      resetn = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
      v8 = 1'b0; kill8 = 1'b0; ordy8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; tag8 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      resetn = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         txn32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, res, tg, lat);
         check($sformatf("v%0d_result", i), res, vecs[i].exp);
         check($sformatf("v%0d_tag", i), 32'(tg), 32'(vecs[i].tag));
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         drain32();
         check($sformatf("v%0d_ready_after", i), 32'(in_ready), 32'd1);
      end

      // Backpressure: result held for 10 cycles, then kill in DONE
      txn32(OP_DIVU, 32'd100, 32'd7, 5'h1A, res, tg, lat);
      check("bp_first_result", res, 32'd14);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         check($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("bp%0d_result", k), out_result, 32'd14);
         check($sformatf("bp%0d_tag", k), 32'(out_tag), 32'h1A);
         check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      end
      kill = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0; out_ready = 1'b0;
      check("kill_done_valid", 32'(out_valid), 32'd0);
      check("kill_done_in_ready", 32'(in_ready), 32'd1);
      check("kill_done_busy", 32'(busy), 32'd0);

      // Kill at CALC cycle 12
      in_op = OP_DIVU; in_a = 32'd1000; in_b = 32'd3; in_tag = 5'h05; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (11) begin
         @(posedge clk); #1;
      end
      check("calc12_busy", 32'(busy), 32'd1);
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      check("kill_calc_in_ready", 32'(in_ready), 32'd1);
      check("kill_calc_busy", 32'(busy), 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("kill_calc_no_valid", 32'(seen), 32'd0);

      // Kill in IDLE blocks acceptance
      in_op = OP_DIVU; in_a = 32'd9; in_b = 32'd3; in_valid = 1'b1; kill = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; kill = 1'b0;
      check("kill_idle_busy", 32'(busy), 32'd0);
      check("kill_idle_in_ready", 32'(in_ready), 32'd1);

      // Unit still works after kills
      txn32(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'h09, res, tg, lat);
      check("post_kill_result", res, 32'hFFFFFFFD);
      check("post_kill_latency", 32'(lat), 32'd34);
      drain32();

      // Reset in the middle of CALC
      in_op = OP_DIVU; in_a = 32'd100; in_b = 32'd7; in_tag = 5'h15; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      resetn = 1'b1;
      @(posedge clk); #1;
      resetn = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_result", out_result, 32'd0);
      check("midrst_out_tag", 32'(out_tag), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("midrst_no_valid", 32'(seen), 32'd0);

      // XLEN=8 instance
      for (int i = 0; i < 4; i++) begin
         txn8(vecs8[i].op, vecs8[i].a[7:0], vecs8[i].b[7:0], vecs8[i].tag, r8, tg, lat);
         check($sformatf("x8_v%0d_result", i), 32'(r8), vecs8[i].exp);
         check($sformatf("x8_v%0d_tag", i), 32'(tg), 32'(vecs8[i].tag));
         check($sformatf("x8_v%0d_latency", i), 32'(lat), 32'(vecs8[i].lat));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
